// File: rtl/jtag_scan_ctrl.sv
// rtl/jtag_scan_ctrl.sv - command-driven JTAG TAP master (TCK/TMS/TDI/TDO scan engine)
// Optional statistics outputs (scan_cnt_o, err_cnt_o) enabled by JTAG_SCAN_STATS_EN.
module jtag_scan_ctrl #(
  parameter int CLK_DIV = 4,
  parameter int MAX_LEN = 64
) (
  input  logic               clk_i,
  input  logic               nrst_i,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic [1:0]         cmd_op_i,
  input  logic [6:0]         cmd_len_i,
  input  logic [MAX_LEN-1:0] cmd_data_i,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic [MAX_LEN-1:0] rsp_data_o,
  output logic               rsp_err_o,
  output logic               tck_o,
  output logic               tms_o,
  output logic               tdi_o,
`ifdef JTAG_SCAN_STATS_EN
  output logic [31:0]        scan_cnt_o,
  output logic [15:0]        err_cnt_o,
`endif
  input  logic               tdo_i
);

  typedef enum logic [1:0] {ST_IDLE, ST_LOW, ST_HIGH, ST_RESP} state_e;

  localparam logic [1:0] OP_RESET = 2'd0;
  localparam logic [1:0] OP_IR    = 2'd1;
  localparam logic [1:0] OP_DR    = 2'd2;
  localparam logic [1:0] OP_IDLE  = 2'd3;

  localparam logic [7:0]         DIV_LAST  = 8'(CLK_DIV - 1);
  localparam logic [7:0]         MAX_LEN_C = 8'(MAX_LEN);
  localparam logic [MAX_LEN-1:0] ONE       = {{(MAX_LEN-1){1'b0}}, 1'b1};

  state_e             state_q, state_d;
  logic [7:0]         div_q;
  logic [7:0]         idx_q;
  logic [7:0]         ntck_q;
  logic [7:0]         k_q;
  logic [1:0]         op_q;
  logic [6:0]         len_q;
  logic [MAX_LEN-1:0] sr_q;
  logic [MAX_LEN-1:0] cap_q;
  logic               shift_q;
  logic               tms_q;
  logic               tdi_q;
  logic               err_q;
  logic               synced_q;

  logic [7:0] cmd_len8;
  logic [7:0] cmd_ntck;
  logic       is_scan;
  logic       reject;
  logic       empty;
  logic       accept;
  logic       div_done;
  logic       last_tck;
  logic [1:0] ctl_first;
  logic [1:0] ctl_next;

  // Returns {shift_bit, tms} for TCK number i of a command, TAP starting in Run-Test/Idle.
  function automatic logic [1:0] bit_ctl(input logic [1:0] op, input logic [7:0] len,
                                         input logic [7:0] i);
    logic [7:0] pre;
    logic       sh;
    logic       tms;
    pre = (op == OP_IR) ? 8'd4 : 8'd3;
    sh  = 1'b0;
    tms = 1'b0;
    case (op)
      OP_RESET: tms = (i < 8'd5);
      OP_IDLE:  tms = 1'b0;
      default: begin
        if (i < pre) begin
          tms = (op == OP_IR) ? (i < 8'd2) : (i == 8'd0);
        end else if (i < pre + len) begin
          sh  = 1'b1;
          tms = (i == pre + len - 8'd1);
        end else begin
          tms = (i == pre + len);
        end
      end
    endcase
    return {sh, tms};
  endfunction

  assign cmd_len8  = {1'b0, cmd_len_i};
  assign is_scan   = (cmd_op_i == OP_IR) || (cmd_op_i == OP_DR);
  assign reject    = is_scan && (!synced_q || (cmd_len_i == 7'd0) || (cmd_len8 > MAX_LEN_C));
  assign empty     = (cmd_op_i == OP_IDLE) && (cmd_len_i == 7'd0);
  assign accept    = (state_q == ST_IDLE) && cmd_valid_i;
  assign div_done  = (div_q == DIV_LAST);
  assign last_tck  = (idx_q == ntck_q - 8'd1);
  assign ctl_first = bit_ctl(cmd_op_i, cmd_len8, 8'd0);
  assign ctl_next  = bit_ctl(op_q, {1'b0, len_q}, idx_q + 8'd1);

  always_comb begin
    cmd_ntck = cmd_len8;
    case (cmd_op_i)
      OP_RESET: cmd_ntck = 8'd6;
      OP_IR:    cmd_ntck = 8'd6 + cmd_len8;
      OP_DR:    cmd_ntck = 8'd5 + cmd_len8;
      default:  cmd_ntck = cmd_len8;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!nrst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i) state_d = (reject || empty) ? ST_RESP : ST_LOW;
      end
      ST_LOW: begin
        if (div_done) state_d = ST_HIGH;
      end
      ST_HIGH: begin
        if (div_done) state_d = last_tck ? ST_RESP : ST_LOW;
      end
      ST_RESP: begin
        if (rsp_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready_o = (state_q == ST_IDLE);
    rsp_valid_o = (state_q == ST_RESP);
    tck_o       = (state_q == ST_HIGH);
    tms_o       = tms_q;
    tdi_o       = tdi_q;
    rsp_data_o  = cap_q;
    rsp_err_o   = err_q;
  end

  always_ff @(posedge clk_i) begin
    if (!nrst_i) begin
      div_q    <= 8'd0;
      idx_q    <= 8'd0;
      ntck_q   <= 8'd0;
      k_q      <= 8'd0;
      op_q     <= OP_RESET;
      len_q    <= 7'd0;
      sr_q     <= '0;
      cap_q    <= '0;
      shift_q  <= 1'b0;
      tms_q    <= 1'b1;
      tdi_q    <= 1'b0;
      err_q    <= 1'b0;
      synced_q <= 1'b0;
    end else begin
      if ((state_q == ST_LOW) || (state_q == ST_HIGH)) begin
        div_q <= div_done ? 8'd0 : div_q + 8'd1;
      end else begin
        div_q <= 8'd0;
      end

      if (accept) begin
        op_q   <= cmd_op_i;
        len_q  <= cmd_len_i;
        ntck_q <= cmd_ntck;
        sr_q   <= cmd_data_i;
        cap_q  <= '0;
        err_q  <= reject;
        idx_q  <= 8'd0;
        k_q    <= 8'd0;
        if (!(reject || empty)) begin
          tms_q   <= ctl_first[0];
          shift_q <= ctl_first[1];
          tdi_q   <= 1'b0;
        end
      end

      // TDO is stable across the high phase; take it on the first high cycle.
      if ((state_q == ST_HIGH) && (div_q == 8'd0) && shift_q) begin
        cap_q <= cap_q | (ONE << k_q);
        if (!tdo_i) cap_q <= cap_q;
        k_q   <= k_q + 8'd1;
      end

      if ((state_q == ST_HIGH) && div_done) begin
        if (last_tck) begin
          shift_q <= 1'b0;
          tdi_q   <= 1'b0;
          if (op_q == OP_RESET) synced_q <= 1'b1;
        end else begin
          idx_q   <= idx_q + 8'd1;
          tms_q   <= ctl_next[0];
          shift_q <= ctl_next[1];
          tdi_q   <= ctl_next[1] & sr_q[0];
          if (ctl_next[1]) sr_q <= sr_q >> 1;
        end
      end
    end
  end

`ifdef JTAG_SCAN_STATS_EN
  logic [31:0] scan_cnt_q;
  logic [15:0] err_cnt_q;

  always_ff @(posedge clk_i) begin
    if (!nrst_i) begin
      scan_cnt_q <= 32'd0;
      err_cnt_q  <= 16'd0;
    end else if ((state_q == ST_RESP) && rsp_ready_i) begin
      if (err_q) begin
        err_cnt_q <= err_cnt_q + 16'd1;
      end else if ((op_q == OP_IR) || (op_q == OP_DR)) begin
        scan_cnt_q <= scan_cnt_q + 32'd1;
      end
    end
  end

  assign scan_cnt_o = scan_cnt_q;
  assign err_cnt_o  = err_cnt_q;
`endif

endmodule

// File: tb/tb_jtag_scan_ctrl.sv
// tb/tb_jtag_scan_ctrl.sv - directed bench for jtag_scan_ctrl with a behavioural TAP (IDCODE 0x1DEAD3FF, IR_LEN 5)
module tb_jtag_scan_ctrl;

  localparam int CLK_DIV = 4;
  localparam int MAX_LEN = 64;

  logic              clk = 1'b0;
  logic              nrst = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready_o;
  logic [1:0]        cmd_op = 2'd0;
  logic [6:0]        cmd_len = 7'd0;
  logic [MAX_LEN-1:0] cmd_data = '0;
  logic              rsp_valid_o;
  logic              rsp_ready = 1'b0;
  logic [MAX_LEN-1:0] rsp_data_o;
  logic              rsp_err_o;
  logic              tck_o;
  logic              tms_o;
  logic              tdi_o;
  logic              tap_tdo = 1'b0;
`ifdef JTAG_SCAN_STATS_EN
  logic [31:0]       scan_cnt;
  logic [15:0]       err_cnt;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  jtag_scan_ctrl #(.CLK_DIV(CLK_DIV), .MAX_LEN(MAX_LEN)) dut (
    .clk_i       (clk),
    .nrst_i      (nrst),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready_o),
    .cmd_op_i    (cmd_op),
    .cmd_len_i   (cmd_len),
    .cmd_data_i  (cmd_data),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready),
    .rsp_data_o  (rsp_data_o),
    .rsp_err_o   (rsp_err_o),
    .tck_o       (tck_o),
    .tms_o       (tms_o),
    .tdi_o       (tdi_o),
`ifdef JTAG_SCAN_STATS_EN
    .scan_cnt_o  (scan_cnt),
    .err_cnt_o   (err_cnt),
`endif
    .tdo_i       (tap_tdo)
  );

  // Behavioural TAP
  localparam logic [3:0] TLR = 4'd0, RTI = 4'd1, SELDR = 4'd2, CAPDR = 4'd3, SHDR = 4'd4,
                         EX1DR = 4'd5, PADR = 4'd6, EX2DR = 4'd7, UPDR = 4'd8, SELIR = 4'd9,
                         CAPIR = 4'd10, SHIR = 4'd11, EX1IR = 4'd12, PAIR = 4'd13, EX2IR = 4'd14,
                         UPIR = 4'd15;
  localparam logic [4:0] IR_IDCODE = 5'b00001;
  localparam logic [4:0] IR_BYPASS = 5'b11111;

  logic [3:0]  tap_st = TLR;
  logic [4:0]  ir = IR_IDCODE;
  logic [4:0]  ir_sr = 5'd0;
  logic [31:0] dr_sr = 32'd0;
  logic        byp = 1'b0;

  function automatic logic [3:0] tap_next(input logic [3:0] s, input logic t);
    case (s)
      TLR:   return t ? TLR   : RTI;
      RTI:   return t ? SELDR : RTI;
      SELDR: return t ? SELIR : CAPDR;
      CAPDR: return t ? EX1DR : SHDR;
      SHDR:  return t ? EX1DR : SHDR;
      EX1DR: return t ? UPDR  : PADR;
      PADR:  return t ? EX2DR : PADR;
      EX2DR: return t ? UPDR  : SHDR;
      UPDR:  return t ? SELDR : RTI;
      SELIR: return t ? TLR   : CAPIR;
      CAPIR: return t ? EX1IR : SHIR;
      SHIR:  return t ? EX1IR : SHIR;
      EX1IR: return t ? UPIR  : PAIR;
      PAIR:  return t ? EX2IR : PAIR;
      EX2IR: return t ? UPIR  : SHIR;
      default: return t ? SELDR : RTI;
    endcase
  endfunction

  always @(posedge tck_o) begin
    if (tap_st == TLR)   ir <= IR_IDCODE;
    if (tap_st == CAPIR) ir_sr <= 5'b00001;
    if (tap_st == SHIR)  ir_sr <= {tdi_o, ir_sr[4:1]};
    if (tap_st == UPIR)  ir <= ir_sr;
    if (tap_st == CAPDR) begin
      dr_sr <= 32'h1DEAD3FF;
      byp   <= 1'b0;
    end
    if (tap_st == SHDR) begin
      dr_sr <= {tdi_o, dr_sr[31:1]};
      byp   <= tdi_o;
    end
    tap_st <= tap_next(tap_st, tms_o);
  end

  always @(negedge tck_o) begin
    if (tap_st == SHIR)      tap_tdo <= ir_sr[0];
    else if (tap_st == SHDR) tap_tdo <= (ir == IR_BYPASS) ? byp : dr_sr[0];
    else                     tap_tdo <= 1'b0;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  logic [63:0]  rd;
  logic         re;
  int           nt, lt, hmn, hmx;
  logic [127:0] tq;
  logic         st;

  task automatic run_cmd(input logic [1:0] op, input logic [6:0] len, input logic [63:0] data,
                         input int hold, output logic [63:0] rdata, output logic rerr,
                         output int ntck, output int lat, output int hmin, output int hmax,
                         output logic [127:0] tmsq, output logic stable);
    int   cyc;
    int   run;
    logic prev;
    ntck = 0; hmin = 1000; hmax = 0; tmsq = '0; run = 0; prev = 1'b0; stable = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_len = len; cmd_data = data;
    cyc = 0;
    while (!cmd_ready_o && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    @(posedge clk);
    cyc = 0;
    do begin
      @(negedge clk);
      if (cyc == 0) cmd_valid = 1'b0;
      cyc++;
      if (tck_o) begin
        if (!prev) begin
          if (ntck < 128) tmsq[ntck] = tms_o;
          ntck++;
        end
        run++;
      end else begin
        if (prev) begin
          if (run < hmin) hmin = run;
          if (run > hmax) hmax = run;
        end
        run = 0;
      end
      prev = tck_o;
    end while (!rsp_valid_o && cyc < 2000);
    lat = cyc;
    check("rsp_arrived", rsp_valid_o, 1'b1);
    rdata = rsp_data_o;
    rerr  = rsp_err_o;
    repeat (hold) begin
      @(negedge clk);
      if (rsp_valid_o !== 1'b1 || rsp_data_o !== rdata || rsp_err_o !== rerr ||
          cmd_ready_o !== 1'b0 || tck_o !== 1'b0) stable = 1'b0;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("post_hs_ready", cmd_ready_o, 1'b1);
    check("post_hs_valid", rsp_valid_o, 1'b0);
  endtask

  initial begin
    int   cyc;
    logic prev;
    logic quiet;

    repeat (3) @(negedge clk);
    check("rst_cmd_ready", cmd_ready_o, 1'b1);
    check("rst_rsp_valid", rsp_valid_o, 1'b0);
    check("rst_rsp_err", rsp_err_o, 1'b0);
    check("rst_rsp_data", rsp_data_o, 64'd0);
    check("rst_tck", tck_o, 1'b0);
    check("rst_tms", tms_o, 1'b1);
    check("rst_tdi", tdi_o, 1'b0);
    nrst = 1'b1;

    // DR scan before any RESET is rejected without TCK
    run_cmd(2'd2, 7'd32, 64'd0, 0, rd, re, nt, lt, hmn, hmx, tq, st);
    check("unsync_err", re, 1'b1);
    check("unsync_data", rd, 64'd0);
    check("unsync_ntck", nt, 0);
    check("unsync_lat", lt, 1);

    run_cmd(2'd0, 7'd0, 64'd0, 0, rd, re, nt, lt, hmn, hmx, tq, st);
    check("reset_err", re, 1'b0);
    check("reset_ntck", nt, 6);
    check("reset_tms", tq, 128'h1F);
    check("reset_lat", lt, 1 + 2 * CLK_DIV * 6);

    run_cmd(2'd2, 7'd32, 64'd0, 0, rd, re, nt, lt, hmn, hmx, tq, st);
    check("idcode_data", rd, 64'h1DEAD3FF);
    check("idcode_err", re, 1'b0);
    check("idcode_ntck", nt, 37);
    check("idcode_tms", tq, 128'h0000_000C_0000_0001);
    check("idcode_hmin", hmn, CLK_DIV);
    check("idcode_hmax", hmx, CLK_DIV);
    check("idcode_lat", lt, 1 + 2 * CLK_DIV * 37);

    run_cmd(2'd1, 7'd5, 64'h1F, 0, rd, re, nt, lt, hmn, hmx, tq, st);
    check("ir_capture", rd[1:0], 2'b01);
    check("ir_err", re, 1'b0);
    check("ir_ntck", nt, 11);
    check("ir_tms", tq, 128'h303);

    run_cmd(2'd2, 7'd8, 64'hA5, 0, rd, re, nt, lt, hmn, hmx, tq, st);
    check("bypass_data", rd, 64'h4A);
    check("bypass_ntck", nt, 13);

`ifdef JTAG_SCAN_STATS_EN
    check("stats_scan", scan_cnt, 32'd3);
    check("stats_err", err_cnt, 16'd1);
`endif

    run_cmd(2'd2, 7'd0, 64'hFF, 0, rd, re, nt, lt, hmn, hmx, tq, st);
    check("len0_err", re, 1'b1);
    check("len0_ntck", nt, 0);

    run_cmd(2'd1, 7'd65, 64'hFF, 0, rd, re, nt, lt, hmn, hmx, tq, st);
    check("len65_err", re, 1'b1);
    check("len65_data", rd, 64'd0);
    check("len65_ntck", nt, 0);

    run_cmd(2'd3, 7'd0, 64'd0, 0, rd, re, nt, lt, hmn, hmx, tq, st);
    check("idle0_lat", lt, 1);
    check("idle0_ntck", nt, 0);
    check("idle0_err", re, 1'b0);

    run_cmd(2'd3, 7'd3, 64'd0, 10, rd, re, nt, lt, hmn, hmx, tq, st);
    check("idle3_ntck", nt, 3);
    check("idle3_tms", tq, 128'h0);
    check("idle3_lat", lt, 1 + 2 * CLK_DIV * 3);
    check("idle3_hold_stable", st, 1'b1);
    check("idle3_err", re, 1'b0);

    // Abort with reset during DR shift bit 10 (TCK number 14)
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'd2; cmd_len = 7'd32; cmd_data = 64'd0;
    @(posedge clk);
    nt = 0; prev = 1'b0; cyc = 0;
    while (nt < 14 && cyc < 2000) begin
      @(negedge clk);
      if (cyc == 0) cmd_valid = 1'b0;
      cyc++;
      if (tck_o && !prev) nt++;
      prev = tck_o;
    end
    check("abort_reached", nt, 14);
    nrst = 1'b0;
    @(negedge clk);
    check("abort_tck", tck_o, 1'b0);
    check("abort_tms", tms_o, 1'b1);
    check("abort_ready", cmd_ready_o, 1'b1);
    check("abort_valid", rsp_valid_o, 1'b0);
    nrst = 1'b1;
    quiet = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (rsp_valid_o !== 1'b0 || tck_o !== 1'b0) quiet = 1'b0;
    end
    check("abort_no_rsp", quiet, 1'b1);

    run_cmd(2'd2, 7'd32, 64'd0, 0, rd, re, nt, lt, hmn, hmx, tq, st);
    check("abort_unsync_err", re, 1'b1);
    check("abort_unsync_ntck", nt, 0);
`ifdef JTAG_SCAN_STATS_EN
    check("stats_after_rst_scan", scan_cnt, 32'd0);
    check("stats_after_rst_err", err_cnt, 16'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jtag_scan_ctrl.md
Name: jtag_scan_ctrl

Overview:
Command-driven JTAG master that sequences the 4-wire TAP port (TCK/TMS/TDI/TDO) from the 100MHz system clock. It accepts RESET, IR_SCAN, DR_SCAN and IDLE commands over a valid/ready interface and generates the TMS walk and TCK waveform for each. It shifts up to 64 bits LSB-first and returns the captured TDO bits on a response channel. It is the on-chip scan engine that drives jtag_tap directly or in parallel with the cJTAG bridge for self-test.

Parameters:
CLK_DIV, 4, system clocks per TCK half-period (legal range 1..255)
MAX_LEN, 64, maximum shift length in bits; sets the width of cmd_data_i and rsp_data_o

Ports:
clk_i  input  1  system clock; all logic on rising edge
nrst_i  input  1  synchronous active-low reset
cmd_valid_i  input  1  command valid
cmd_ready_o  output  1  command accepted when valid&ready
cmd_op_i  input  2  0=RESET, 1=IR_SCAN, 2=DR_SCAN, 3=IDLE
cmd_len_i  input  7  shift bits (scans) or TCK count (IDLE); 0..MAX_LEN
cmd_data_i  input  MAX_LEN  TDI data, bit0 shifted first
rsp_valid_o  output  1  response valid; held until rsp_ready_i
rsp_ready_i  input  1  response consumed
rsp_data_o  output  MAX_LEN  captured TDO, bit i = i-th shifted bit; bits >= len are 0
rsp_err_o  output  1  command rejected; no TCK edges were generated
tck_o  output  1  JTAG TCK
tms_o  output  1  JTAG TMS
tdi_o  output  1  JTAG TDI
tdo_i  input  1  JTAG TDO from the TAP

Behaviour:
- Reset values: cmd_ready_o=1, rsp_valid_o=0, rsp_err_o=0, rsp_data_o=0, tck_o=0, tms_o=1, tdi_o=0, synced=0, all counters 0.
- Reset mid-operation: the abort completes on the next edge. No response is issued and synced is cleared.
- FSM states: IDLE, LOW, HIGH, RESP.
- IDLE: cmd_ready_o=1 only in this state. On accept, the command is latched and the next state is LOW; the first TCK low phase starts the following cycle.
- Each TCK bit has two phases:
  - LOW phase: tck_o=0; tms_o and tdi_o are updated on entry.
  - HIGH phase: tck_o=1; tdo_i is sampled on the 0->1 transition cycle.
  - Each phase lasts CLK_DIV clocks, tracked by an 8-bit divider counter.
- TMS sequences. The TAP is assumed to be in Run-Test/Idle between commands.
  - RESET: TMS 1,1,1,1,1,0 (6 TCK); sets synced=1.
  - IR_SCAN: TMS 1,1,0,0, then len shift bits with TMS=0 except the last bit TMS=1, then TMS 1,0. Total 6+len TCK.
  - DR_SCAN: TMS 1,0,0, then len shift bits with the same last-bit rule, then TMS 1,0. Total 5+len TCK.
  - IDLE: len TCK with TMS=0.
- TDI:
  - During shift bits, tdi_o = cmd_data bit k.
  - Outside shift bits, tdi_o=0.
  - TDO is captured only on shift bits, into rsp_data bit k.
- Rejection rules:
  - IR/DR_SCAN while synced=0, or with len=0 or len>MAX_LEN: go to RESP with rsp_err_o=1, rsp_data_o=0, zero TCK edges.
  - IDLE with len=0: RESP immediately, err=0.
  - IDLE or RESET are legal while unsynced.
- RESP: rsp_valid_o=1 until rsp_ready_i is seen high. Then go to IDLE, rsp_valid_o=0, cmd_ready_o=1 on the next cycle. There is no command/response overlap.
- rsp_data_o and rsp_err_o are stable while rsp_valid_o=1. tck_o=0 whenever not in HIGH.
- Minimum command-to-response latency is 1 + 2*CLK_DIV*nTCK cycles.

Optional Feature:
JTAG_SCAN_STATS_EN
- Defined: adds output scan_cnt_o [31:0] and output err_cnt_o [15:0].
  - scan_cnt_o increments by 1 on each completed non-error IR/DR_SCAN response handshake.
  - err_cnt_o increments on each rsp_err_o handshake.
  - Both wrap modulo 2^N, reset to 0, and are cleared by nrst_i.
- Undefined: neither port nor counter exists; behaviour is otherwise identical.

Test Plan:
- Reset, then DR_SCAN len=32 data=0 before any RESET -> rsp_err_o=1, rsp_data_o=0, zero tck_o rising edges.
- RESET, then DR_SCAN len=32 data=0 against jtag_tap (IDCODE 0x1DEAD3FF, IR_LEN 5) -> rsp_data_o=0x1DEAD3FF, err=0, exactly 37 tck_o rising edges, each high phase lasting CLK_DIV=4 clocks.
- RESET, IR_SCAN len=5 data=0x1F -> rsp_data_o[1:0]=2'b01; then DR_SCAN len=8 data=0xA5 (BYPASS) -> rsp_data_o=0x4A.
- IDLE len=0 -> rsp_valid_o in the cycle after accept, no TCK. IDLE len=3 -> 3 TCK with tms_o=0. Hold rsp_ready_i=0 for 10 cycles -> rsp_valid_o and data stable, cmd_ready_o=0.
- Assert nrst_i low for 1 cycle during the DR shift of bit 10 -> next cycle tck_o=0, tms_o=1, cmd_ready_o=1, rsp_valid_o=0; a subsequent DR_SCAN is rejected (synced cleared).
- With JTAG_SCAN_STATS_EN: 3 good scans plus 1 rejected -> scan_cnt_o=3, err_cnt_o=1.
